instr_prefetch_queue: RTL and testbench
=======================================

# instr_prefetch_queue

Instruction fetch front end between the instruction memory and the CPU decode path. Tracks the fetch PC, issues one-outstanding-at-a-time word reads over a req/ack handshake to a variable-latency instruction memory, and buffers returned instructions with their PCs in a small FIFO. Presents them to decode over a valid/ready handshake. Accepts a branch/jump redirect that flushes the queue and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- mem_req_o  out  1  read request to instruction memory (registered)
- mem_addr_o  out  32  word address of request (registered, bits[1:0]=0)
- mem_ack_i  in  1  request complete; mem_data_i valid this cycle
- mem_data_i  in  32  instruction word
- redirect_i  in  1  flush queue, restart fetch
- redirect_pc_i  in  32  new fetch PC; bits[1:0] forced to 0
- instr_valid_o  out  1  head entry valid
- instr_o  out  32  head instruction
- instr_pc_o  out  32  PC of head instruction
- instr_ready_i  in  1  decode accepts head this cycle
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Reset: mem_req_o=0, mem_addr_o=0, count_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0; fetch_pc=RESET_PC; state IDLE; drop flag 0.
- States: IDLE (no request), REQ (request outstanding, data kept), DROP (request outstanding, data discarded on ack).
- IDLE→REQ when count_o < DEPTH: mem_req_o=1, mem_addr_o=fetch_pc.
- In REQ/DROP, mem_req_o and mem_addr_o held stable until mem_ack_i; never withdrawn or changed mid-transaction, including on redirect.
- mem_ack_i ignored while mem_req_o=0.
- Ack in REQ: write {mem_data_i, mem_addr_o} at tail; fetch_pc = mem_addr_o+4 (32-bit wrap, 0xFFFF_FFFC→0). If (count + 1 − pop) < DEPTH, stay REQ with new address next cycle; else IDLE.
- Ack in DROP: discard data; go REQ at fetch_pc (the redirect target) if space, else IDLE.
- Pop: instr_valid_o && instr_ready_i; head advances. Simultaneous push and pop leaves count unchanged.
- instr_valid_o = (count_o != 0); instr_o/instr_pc_o are head entry contents, 0 when empty.
- Redirect in cycle N: FIFO flushed (count 0 at N+1, any pop/push at N discarded); fetch_pc=redirect_pc_i & ~3. If IDLE→REQ at N+1 with new address. If REQ or DROP and ack not at N→DROP. If ack at N, ack data dropped, REQ at N+1 with new address.
- Back-to-back redirects: last one wins; at most one stale ack discarded.
- Pointers wrap modulo DEPTH; no overflow possible because requests issue only with space reserved.

## Timing
- First mem_req_o rises the first cycle after rst_i deasserts.
- Ack at cycle N → instruction visible on instr_o at N+1.
- Peak throughput 1 instruction/cycle when memory acks in the request's first cycle.
- Redirect at N → instr_valid_o=0 at N+1; new-target request at N+1 (idle or simultaneous ack) or the cycle after the stale ack.
- rst_i asserted at any time clears all state immediately, including an outstanding request (mem_req_o=0 asynchronously); memory must tolerate an abandoned request.

## Test plan
- Reset, ready=1, memory acks in request cycle with data=addr^32'hA5A5_0000 → instr_pc_o 0,4,8,0xC… one per cycle, instr_o matches, mem_req_o continuously high.
- instr_ready_i=0 → after 4 acks count_o=4, mem_req_o=0 with fetch_pc 0x10; ready=1 one cycle → count 3, mem_req_o=1, mem_addr_o=0x10 next cycle.
- Full queue, idle, redirect_pc_i=0x103 → next cycle count_o=0, instr_valid_o=0, mem_addr_o=0x100; first popped instr_pc_o=0x100.
- Request at 0x8 acked 3 cycles late, redirect to 0x200 in cycle 1 → mem_addr_o stays 0x8 until ack, data not enqueued, next request 0x200.
- Redirect to 0x40 in same cycle as ack and pop → ack data dropped, count_o=0 next cycle, mem_addr_o=0x40.
- RESET_PC=0xFFFF_FFFC → instr_pc_o 0xFFFF_FFFC then 0x0; rst_i pulse mid-request → mem_req_o=0 immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch PC tracker, single-outstanding memory requester and instruction FIFO with redirect flush
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_data_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       instr_valid_o,
  output logic [31:0]                instr_o,
  output logic [31:0]                instr_pc_o,
  input  logic                       instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic            req_q, req_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_mem [DEPTH];
  logic [31:0]     pc_mem [DEPTH];
  logic            ack, pop, push, issue;
  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign count_o       = count_q;
  assign instr_valid_o = count_q != '0;
  assign instr_o       = instr_valid_o ? data_mem[head_q] : '0;
  assign instr_pc_o    = instr_valid_o ? pc_mem[head_q] : '0;
  // A new request may start only once the previous one is acked (or none is pending),
  // and only if the slot it will fill is already free after this cycle's push/pop.
  always_comb begin
    ack        = mem_ack_i && req_q;
    pop        = instr_valid_o && instr_ready_i;
    push       = ack && state_q == REQ && !redirect_i;
    count_d    = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    head_d     = redirect_i ? '0 : head_q + AW'(pop);
    tail_d     = redirect_i ? '0 : tail_q + AW'(push);
    fetch_pc_d = redirect_i ? {redirect_pc_i[31:2], 2'b00}
               : (ack && state_q == REQ) ? addr_q + 32'd4 : fetch_pc_q;
    issue      = (state_q == IDLE || ack) && count_d < CW'(DEPTH);
    state_d    = issue ? REQ
               : (state_q == IDLE || ack) ? IDLE
               : redirect_i ? DROP : state_q;
    req_d      = state_d != IDLE;
    addr_d     = issue ? fetch_pc_d : addr_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[tail_q] <= mem_data_i;
      pc_mem[tail_q]   <= addr_q;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: randomized bench against a queue-based reference model
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  logic        clk = 0, rst_i = 1;
  logic        mem_req_o, mem_ack_i, redirect_i, instr_valid_o, instr_ready_i;
  logic [31:0] mem_addr_o, mem_data_i, redirect_pc_i, instr_o, instr_pc_o;
  logic [2:0]  count_o;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;
  logic [2:0]  count2;
  always #5 clk = ~clk;
  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i), .count_o(count_o));
  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .mem_req_o(req2), .mem_addr_o(addr2),
    .mem_ack_i(req2), .mem_data_i(addr2 ^ 32'hA5A5_0000), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .instr_valid_o(valid2), .instr_o(instr2),
    .instr_pc_o(pc2), .instr_ready_i(1'b1), .count_o(count2));
  int checks = 0, errors = 0;
  logic [31:0] mq_data[$], mq_pc[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_busy, m_stale, rst_done;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    mq_data.delete();
    mq_pc.delete();
    m_fpc   = 32'h0;
    m_addr  = 32'h0;
    m_busy  = 0;
    m_stale = 0;
  endtask
  task automatic check_outputs();
    int n = mq_data.size();
    chk("req", 32'(mem_req_o), 32'(m_busy));
    if (m_busy) chk("addr", mem_addr_o, m_addr);
    chk("count", 32'(count_o), n);
    chk("valid", 32'(instr_valid_o), 32'(n != 0));
    chk("instr", instr_o, n != 0 ? mq_data[0] : 32'h0);
    chk("pc", instr_pc_o, n != 0 ? mq_pc[0] : 32'h0);
  endtask
  // Advance the model by one clock using the inputs just driven.
  task automatic model_step();
    bit got_ack = mem_ack_i && m_busy;
    if (redirect_i) begin
      mq_data.delete();
      mq_pc.delete();
      m_fpc = redirect_pc_i & ~32'd3;
      if (!m_busy || got_ack) begin
        m_busy  = 1;
        m_stale = 0;
        m_addr  = m_fpc;
      end else m_stale = 1;
    end else begin
      if (mq_data.size() != 0 && instr_ready_i) begin
        void'(mq_data.pop_front());
        void'(mq_pc.pop_front());
      end
      if (got_ack) begin
        if (!m_stale) begin
          mq_data.push_back(mem_data_i);
          mq_pc.push_back(m_addr);
          m_fpc = m_addr + 32'd4;
        end
        m_busy  = 0;
        m_stale = 0;
      end
      if (!m_busy && mq_data.size() < DEPTH) begin
        m_busy = 1;
        m_addr = m_fpc;
      end
    end
  endtask
  initial begin
    mem_ack_i = 0; mem_data_i = 0; redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wrap_req", 32'(req2), 32'h0);
    rst_i = 0;
    model_step();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc == 0) begin
        chk("wrap_req", 32'(req2), 32'h1);
        chk("wrap_addr", addr2, 32'hFFFF_FFFC);
      end
      if (cyc == 1) begin
        chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
        chk("wrap_instr0", instr2, 32'h5A5A_FFFC);
      end
      if (cyc == 2) chk("wrap_pc1", pc2, 32'h0);
      if (cyc >= 1 && cyc <= 20) begin
        chk("stream_pc", instr_pc_o, 32'((cyc - 1) * 4));
        chk("stream_instr", instr_o, 32'((cyc - 1) * 4) ^ 32'hA5A5_0000);
        chk("stream_req", 32'(mem_req_o), 32'h1);
      end
      if (!rst_done && cyc >= 1500 && m_busy) begin
        rst_i = 1;
        #1;
        chk("async_rst_req", 32'(mem_req_o), 32'h0);
        chk("async_rst_count", 32'(count_o), 32'h0);
        model_reset();
        #2;
        rst_i = 0;
        rst_done = 1;
      end
      if (cyc < 200) begin
        instr_ready_i = 1;
        mem_ack_i     = 1;
        redirect_i    = 0;
        mem_data_i    = m_addr ^ 32'hA5A5_0000;
      end else if (cyc < 400) begin
        instr_ready_i = $urandom_range(9) == 0;
        mem_ack_i     = $urandom_range(1) == 1;
        redirect_i    = 0;
        mem_data_i    = $urandom;
      end else begin
        instr_ready_i = $urandom_range(1) == 1;
        mem_ack_i     = $urandom_range(4) < 2;
        redirect_i    = $urandom_range(15) == 0;
        mem_data_i    = $urandom;
      end
      redirect_pc_i = $urandom;
      if ($urandom_range(1) == 1) redirect_pc_i[31:8] = '1;
      model_step();
    end
    chk("mid_reset_done", 32'(rst_done), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
